// File: rtl/cmos_crop_win.sv
// cmos_crop_win: crops a DE-framed pixel stream to a window latched at each frame start.
// Optional 2:1 decimation in both axes when CROP_DECIMATE_EN is defined.
module cmos_crop_win #(
  parameter int unsigned IMG_W = 1280,
  parameter int unsigned IMG_H = 720,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs_in,
  input  logic          de_in,
  input  logic [DW-1:0] pix_in,
  input  logic [CW-1:0] cfg_x0,
  input  logic [CW-1:0] cfg_x1,
  input  logic [CW-1:0] cfg_y0,
  input  logic [CW-1:0] cfg_y1,
  input  logic          cfg_decim,
  output logic          vs_out,
  output logic          de_out,
  output logic [DW-1:0] pix_out,
  output logic          line_err
);

  localparam logic [CW-1:0] W_MAX = CW'(IMG_W);
  localparam logic [CW-1:0] H_MAX = CW'(IMG_H);

  logic          r_vs_d;
  logic          r_de_d;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic [CW-1:0] r_x0;
  logic [CW-1:0] r_x1;
  logic [CW-1:0] r_y0;
  logic [CW-1:0] r_y1;

  logic w_vs_rise;
  logic w_line_end;
  logic w_h_ovf;
  logic w_v_ovf;
  logic w_in_win;
  logic w_decim_ok;
  logic w_pix_ok;

  assign w_vs_rise  = vs_in & ~r_vs_d;
  assign w_line_end = r_de_d & ~de_in;
  assign w_h_ovf    = (r_hc == W_MAX);
  assign w_v_ovf    = (r_vc == H_MAX);
  assign w_in_win   = (r_hc >= r_x0) && (r_hc < r_x1) && (r_vc >= r_y0) && (r_vc < r_y1);

`ifdef CROP_DECIMATE_EN
  logic r_decim;

  // (hc - x0) even is the same as matching LSBs; likewise for rows.
  assign w_decim_ok = ~r_decim | ((r_hc[0] == r_x0[0]) & (r_vc[0] == r_y0[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decim <= 1'b0;
    end else if (w_vs_rise) begin
      r_decim <= cfg_decim;
    end
  end
`else
  logic w_unused_decim;

  assign w_unused_decim = cfg_decim;
  assign w_decim_ok     = 1'b1;
`endif

  assign w_pix_ok = de_in & ~vs_in & ~w_h_ovf & ~w_v_ovf & w_in_win & w_decim_ok;

  // Shadow window, clipped to the image so out-of-range bounds shrink the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y0 <= '0;
      r_y1 <= '0;
    end else if (w_vs_rise) begin
      r_x0 <= (cfg_x0 > W_MAX) ? W_MAX : cfg_x0;
      r_x1 <= (cfg_x1 > W_MAX) ? W_MAX : cfg_x1;
      r_y0 <= (cfg_y0 > H_MAX) ? H_MAX : cfg_y0;
      r_y1 <= (cfg_y1 > H_MAX) ? H_MAX : cfg_y1;
    end
  end

  // Position counters; de history is cleared under vsync so an aborted line
  // does not register as a line end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_hc   <= '0;
      r_vc   <= '0;
    end else begin
      r_vs_d <= vs_in;
      r_de_d <= de_in & ~vs_in;
      if (vs_in) begin
        r_hc <= '0;
        r_vc <= '0;
      end else if (w_line_end) begin
        r_hc <= '0;
        if (!w_v_ovf) r_vc <= r_vc + CW'(1);
      end else if (de_in && !w_h_ovf) begin
        r_hc <= r_hc + CW'(1);
      end
    end
  end

  // Registered outputs; pix_out only updates on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_out   <= 1'b0;
      de_out   <= 1'b0;
      pix_out  <= '0;
      line_err <= 1'b0;
    end else begin
      vs_out <= vs_in;
      de_out <= w_pix_ok;
      if (w_pix_ok) pix_out <= pix_in;
      if (w_vs_rise) begin
        line_err <= 1'b0;
      end else if (de_in && !vs_in && (w_h_ovf || w_v_ovf)) begin
        line_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cmos_crop_win.md
CMOS_CROP_WIN -- requirements
Module: cmos_crop_win

Interface
REQ-001 Parameter IMG_W, default 1280: active pixels per input line.
REQ-002 Parameter IMG_H, default 720: active lines per input frame.
REQ-003 Parameter DW, default 16: pixel width in bits (RGB565 at default).
REQ-004 Parameter CW, default 12: coordinate and counter width; CW SHALL be ≥ clog2(max(IMG_W,IMG_H)+1).
REQ-005 clk  in  1  pixel clock; all logic is in this single domain.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 vs_in  in  1  input vertical sync, active high, frame boundary.
REQ-008 de_in  in  1  input data enable, one pixel per cycle when high.
REQ-009 pix_in  in  DW  input pixel.
REQ-010 cfg_x0, cfg_x1  in  CW  window columns, start inclusive, end exclusive.
REQ-011 cfg_y0, cfg_y1  in  CW  window rows, start inclusive, end exclusive.
REQ-012 cfg_decim  in  1  2:1 decimation request; used only when CROP_DECIMATE_EN is defined.
REQ-013 vs_out  out  1  vs_in delayed 1 cycle.
REQ-014 de_out  out  1  cropped data enable, registered.
REQ-015 pix_out  out  DW  pixel aligned to de_out, registered.
REQ-016 line_err  out  1  sticky per frame: a line exceeded IMG_W or the frame exceeded IMG_H lines.

Function
REQ-017 The window config SHALL be sampled into shadow registers on the first cycle vs_in is high (rising edge); mid-frame cfg changes SHALL have no effect until the next frame.
REQ-018 The column counter hc SHALL increment on each de_in cycle and clear to 0 on the cycle after de_in falls (line end).
REQ-019 The row counter vc SHALL increment at each line end.
REQ-020 hc and vc SHALL clear to 0 synchronously while vs_in is high.
REQ-021 A pixel is in-window when x0 ≤ hc < x1 and y0 ≤ vc < y1, using the shadow values and the pre-increment hc/vc.
REQ-022 de_out SHALL be high exactly one cycle after an in-window de_in cycle; pix_out SHALL carry that pixel; latency 1 cycle.
REQ-023 pix_out SHALL hold its last value when de_out is low.
REQ-024 When x0 ≥ x1 or y0 ≥ y1, or a window bound exceeds IMG_W/IMG_H, the window SHALL be clipped to the image; an empty window yields no de_out for the whole frame.
REQ-025 If hc reaches IMG_W with de_in still high, hc SHALL saturate at IMG_W, further pixels SHALL be dropped, and line_err SHALL set.
REQ-026 If vc reaches IMG_H, vc SHALL saturate, all further pixels in that frame SHALL be dropped, and line_err SHALL set.
REQ-027 line_err SHALL clear on vs_in rising edge.
REQ-028 vs_in high mid-line SHALL abort the line: de_out low from the next cycle, and the counters cleared.

Reset
REQ-029 On rst_n low: hc, vc, and shadow registers SHALL be 0; vs_out, de_out, pix_out, and line_err SHALL be 0.
REQ-030 Until the first vs_in rising edge after reset, de_out SHALL stay 0 because the shadow window is empty.

Configuration
REQ-031 Macro CROP_DECIMATE_EN defined: cfg_decim is sampled into the shadow registers with the window. When it is 1, only pixels with (hc−x0) even and (vc−y0) even are output, giving a quarter-area output.
REQ-032 Macro CROP_DECIMATE_EN undefined: cfg_decim SHALL be ignored, and no decimation logic SHALL be synthesised.

Verification
REQ-033 Test 1. Stimulus: 1280x720 frame, window 160..1120 x 90..630. Response: exactly 540 lines of 960 de_out pulses each, with data equal to the input shifted by 1 cycle.
REQ-034 Test 2. Stimulus: cfg changed to 0..640 x 0..360 mid-frame. Response: the current frame still gives 960x540; the next frame gives 640x360.
REQ-035 Test 3. Stimulus: cfg_x0 = 700, cfg_x1 = 600. Response: zero de_out pulses for the frame, and line_err = 0.
REQ-036 Test 4. Stimulus: one 1300-pixel line. Response: pixels 1280..1299 are dropped, line_err = 1, and line_err clears at the next vs_in.
REQ-037 Test 5. Stimulus: rst_n pulsed low mid-line. Response: all outputs are 0 immediately, and no de_out until after the next vs_in edge.
REQ-038 Test 6. Stimulus: CROP_DECIMATE_EN defined, cfg_decim = 1, window 0..8 x 0..4. Response: 2 lines of 4 pixels, at columns 0, 2, 4, 6 of rows 0 and 2.
